pf_ddr_dqs_eye_trainer: RTL and testbench

//   Parametrised read-DQS eye trainer for the NUM_LANES DQS IOD lanes of the DDR PHY block.

---
 rtl/pf_ddr_dqs_eye_trainer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_pf_ddr_dqs_eye_trainer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_ddr_dqs_eye_trainer.sv
// pf_ddr_dqs_eye_trainer
//   Read-DQS eye trainer for NUM_LANES DDR PHY DQS IOD lanes. Lanes are trained
//   one at a time. Each lane's delay line is swept from tap 0 upward while the
//   EARLY/LATE eye-monitor flags are sampled. The longest passing window is
//   kept, with the lowest window winning a tie. The line is then reloaded and
//   stepped to the window centre.
//   Optional feature macro: DQS_TRAIN_WINDOW_REPORT_EN adds the WINDOW_LEN
//   output, which holds the best window length per lane.
module pf_ddr_dqs_eye_trainer #(
  parameter int NUM_LANES     = 4,
  parameter int TAP_W         = 8,
  parameter int DELAY_TAPS    = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int MIN_WINDOW    = 4
) (
  input  logic                         FAB_CLK,
  input  logic                         RESET_N,
  input  logic                         START,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [NUM_LANES-1:0]         ERROR,
  output logic [NUM_LANES*TAP_W-1:0]   CENTER_TAP,
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
  output logic [NUM_LANES*TAP_W-1:0]   WINDOW_LEN,
`endif
  output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]         EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
  input  logic [NUM_LANES-1:0]         EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]         EYE_MONITOR_LATE
);

  localparam int LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int LEN_W = TAP_W + 1;   // window length can reach 2**TAP_W
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
    S_STEP, S_EVAL, S_CLOAD, S_CSTEP, S_NEXT
  } state_e;

  state_e                     state_q, state_d;
  logic [LW-1:0]              lane_q, lane_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [TAP_W-1:0]           cnt_q, cnt_d;
  logic                       gap_q, gap_d;
  logic [SW-1:0]              settle_q, settle_d;
  logic [TAP_W-1:0]           cur_start_q, cur_start_d;
  logic [LEN_W-1:0]           cur_len_q, cur_len_d;
  logic [TAP_W-1:0]           best_start_q, best_start_d;
  logic [LEN_W-1:0]           best_len_q, best_len_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [NUM_LANES-1:0]       error_q, error_d;
  logic [NUM_LANES*TAP_W-1:0] center_q, center_d;
  logic [NUM_LANES-1:0]       load_q, load_d;
  logic [NUM_LANES-1:0]       move_q, move_d;
  logic [NUM_LANES-1:0]       clr_q, clr_d;
  logic [NUM_LANES-1:0]       dir_q;
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
  logic [NUM_LANES*TAP_W-1:0] win_q, win_d;
`endif

  logic [NUM_LANES-1:0]       sel_s;
  logic                       pass_s;
  logic                       oor_s;
  int                         lane_base_s;
  logic [TAP_W-1:0]           ctr_sel_s;
  logic [TAP_W-1:0]           ctr_calc_s;
  logic [LEN_W-1:0]           new_len_s;

  assign sel_s       = NUM_LANES'(1) << lane_q;
  assign pass_s      = !EYE_MONITOR_EARLY[lane_q] && !EYE_MONITOR_LATE[lane_q];
  assign oor_s       = DELAY_LINE_OUT_OF_RANGE[lane_q];
  assign lane_base_s = int'(lane_q) * TAP_W;
  assign ctr_sel_s   = center_q[lane_base_s +: TAP_W];
  assign ctr_calc_s  = best_start_q + TAP_W'((best_len_q - LEN_W'(1)) >> 1);
  assign new_len_s   = cur_len_q + LEN_W'(1);

  // Next-state, window search and pulse generation for the training sequence.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    settle_d     = settle_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    done_d       = done_q;
    error_d      = error_q;
    center_d     = center_q;
    load_d       = '0;
    move_d       = '0;
    clr_d        = '0;
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
    win_d        = win_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          done_d   = 1'b0;
          error_d  = '0;
          center_d = '0;
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
          win_d    = '0;
`endif
          lane_d   = '0;
          state_d  = S_LOAD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD: begin
        load_d       = sel_s;
        tap_d        = '0;
        cur_start_d  = '0;
        cur_len_d    = '0;
        best_start_d = '0;
        best_len_d   = '0;
        state_d      = S_CLEAR;
      end
      S_CLEAR: begin
        clr_d    = sel_s;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d  = S_SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_SAMPLE: begin
        if (pass_s) begin
          // A run that starts at this tap has its start captured here.
          if (cur_len_q == LEN_W'(0)) begin
            cur_start_d = tap_q;
          end else begin
            cur_start_d = cur_start_q;
          end
          cur_len_d = new_len_s;
          // Strict compare keeps the lowest window on equal lengths.
          if (new_len_s > best_len_q) begin
            best_start_d = (cur_len_q == LEN_W'(0)) ? tap_q : cur_start_q;
            best_len_d   = new_len_s;
          end else begin
            best_len_d   = best_len_q;
          end
        end else begin
          cur_len_d = '0;
        end
        if ((tap_q == TAP_W'(DELAY_TAPS - 1)) || oor_s) begin
          state_d = S_EVAL;
        end else begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        move_d  = sel_s;
        tap_d   = tap_q + TAP_W'(1);
        state_d = S_CLEAR;
      end
      S_EVAL: begin
        if (best_len_q < LEN_W'(MIN_WINDOW)) begin
          error_d[lane_q]                  = 1'b1;
          center_d[lane_base_s +: TAP_W]   = '0;
        end else begin
          center_d[lane_base_s +: TAP_W]   = ctr_calc_s;
        end
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
        win_d[lane_base_s +: TAP_W] = best_len_q[TAP_W-1:0];
`endif
        state_d = S_CLOAD;
      end
      S_CLOAD: begin
        load_d  = sel_s;
        cnt_d   = '0;
        gap_d   = 1'b0;
        state_d = S_CSTEP;
      end
      S_CSTEP: begin
        // Every MOVE is followed by an idle cycle so pulses never abut.
        if (gap_q) begin
          gap_d   = 1'b0;
        end else if (cnt_q < ctr_sel_s) begin
          move_d  = sel_s;
          cnt_d   = cnt_q + TAP_W'(1);
          gap_d   = 1'b1;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (lane_q == LW'(NUM_LANES - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          lane_d  = lane_q + LW'(1);
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= 1'b0;
      settle_q     <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= '0;
      center_q     <= '0;
      load_q       <= '0;
      move_q       <= '0;
      clr_q        <= '0;
      dir_q        <= '0;
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
      win_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      settle_q     <= settle_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      center_q     <= center_d;
      load_q       <= load_d;
      move_q       <= move_d;
      clr_q        <= clr_d;
      dir_q        <= '1;
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
      win_q        <= win_d;
`endif
    end
  end

  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign ERROR                   = error_q;
  assign CENTER_TAP              = center_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
  assign WINDOW_LEN              = win_q;
`endif

endmodule

// File: tb/tb_pf_ddr_dqs_eye_trainer.sv
// Bench for pf_ddr_dqs_eye_trainer. It emulates per-lane IOD delay lines and
// eye monitors from a pass/fail map per tap. Expected centres are computed
// from the longest-run rule applied directly to those maps.
module tb_pf_ddr_dqs_eye_trainer;

  localparam int NL = 4;
  localparam int TW = 8;
  localparam int DT = 32;
  localparam int SC = 2;
  localparam int MW = 4;

  logic              FAB_CLK;
  logic              RESET_N;
  logic              START;
  logic              BUSY;
  logic              DONE;
  logic [NL-1:0]     ERROR;
  logic [NL*TW-1:0]  CENTER_TAP;
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
  logic [NL*TW-1:0]  WINDOW_LEN;
`endif
  logic [NL-1:0]     DELAY_LINE_LOAD;
  logic [NL-1:0]     DELAY_LINE_MOVE;
  logic [NL-1:0]     DELAY_LINE_DIRECTION;
  logic [NL-1:0]     EYE_MONITOR_CLEAR_FLAGS;
  logic [NL-1:0]     DELAY_LINE_OUT_OF_RANGE;
  logic [NL-1:0]     EYE_MONITOR_EARLY;
  logic [NL-1:0]     EYE_MONITOR_LATE;

  pf_ddr_dqs_eye_trainer #(
    .NUM_LANES(NL), .TAP_W(TW), .DELAY_TAPS(DT), .SETTLE_CYCLES(SC), .MIN_WINDOW(MW)
  ) dut (
    .FAB_CLK(FAB_CLK),
    .RESET_N(RESET_N),
    .START(START),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERROR(ERROR),
    .CENTER_TAP(CENTER_TAP),
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
    .WINDOW_LEN(WINDOW_LEN),
`endif
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE(EYE_MONITOR_LATE)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  int checks = 0;
  int errors = 0;

  // Eye description per lane: pass map over taps and end-stop tap.
  logic [DT-1:0] pass_m [NL];
  int            oor_at [NL];
  int            tap_e  [NL];

  // Monitor state.
  logic mon_rst = 1'b0;
  int   mon_bad, mon_consec, cur_lane;
  logic prev_move;
  int   load_cnt [NL];
  int   moves_c  [NL];
  int   load_seq [$];

  function automatic int lane_of(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Delay-line emulation: LOAD returns to tap 0, MOVE increments.
  always @(negedge FAB_CLK) begin
    for (int i = 0; i < NL; i++) begin
      if (DELAY_LINE_LOAD[i]) tap_e[i] <= 0;
      else if (DELAY_LINE_MOVE[i]) tap_e[i] <= tap_e[i] + 1;
    end
  end

  // Eye-monitor emulation driven from the emulated tap position.
  always_comb begin
    EYE_MONITOR_EARLY       = '0;
    EYE_MONITOR_LATE        = '0;
    DELAY_LINE_OUT_OF_RANGE = '0;
    for (int i = 0; i < NL; i++) begin
      if (!((tap_e[i] < DT) && pass_m[i][tap_e[i]])) begin
        if (tap_e[i] < 16) EYE_MONITOR_EARLY[i] = 1'b1;
        else               EYE_MONITOR_LATE[i]  = 1'b1;
      end
      DELAY_LINE_OUT_OF_RANGE[i] = (tap_e[i] >= oor_at[i]);
    end
  end

  // Pulse monitor: lane ordering, lane isolation, MOVE spacing and counts.
  always @(negedge FAB_CLK) begin
    if (mon_rst) begin
      mon_bad    <= 0;
      mon_consec <= 0;
      prev_move  <= 1'b0;
      load_seq.delete();
      for (int i = 0; i < NL; i++) begin
        load_cnt[i] <= 0;
        moves_c[i]  <= 0;
      end
    end else begin
      if (DELAY_LINE_LOAD != '0) begin
        load_seq.push_back(lane_of(DELAY_LINE_LOAD));
        cur_lane <= lane_of(DELAY_LINE_LOAD);
        load_cnt[lane_of(DELAY_LINE_LOAD)] <= load_cnt[lane_of(DELAY_LINE_LOAD)] + 1;
        if (!$onehot(DELAY_LINE_LOAD) || ((DELAY_LINE_MOVE | EYE_MONITOR_CLEAR_FLAGS) != '0))
          mon_bad <= mon_bad + 1;
      end else if ((DELAY_LINE_MOVE | EYE_MONITOR_CLEAR_FLAGS) != '0) begin
        if (!$onehot(DELAY_LINE_MOVE | EYE_MONITOR_CLEAR_FLAGS) ||
            (((DELAY_LINE_MOVE | EYE_MONITOR_CLEAR_FLAGS) & ~(NL'(1) << cur_lane)) != '0))
          mon_bad <= mon_bad + 1;
      end
      for (int i = 0; i < NL; i++)
        if (DELAY_LINE_MOVE[i] && load_cnt[i] >= 2) moves_c[i] <= moves_c[i] + 1;
      if ((DELAY_LINE_MOVE != '0) && prev_move) mon_consec <= mon_consec + 1;
      prev_move <= (DELAY_LINE_MOVE != '0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: longest passing run over the scanned taps, lowest run on ties.
  function automatic void ref_lane(input logic [DT-1:0] pm, input int oor,
                                   output int ctr, output int err, output int blen);
    int last, s, e, bs;
    last = (oor < DT - 1) ? oor : DT - 1;
    bs = 0; blen = 0; s = 0;
    while (s <= last) begin
      if (pm[s]) begin
        e = s;
        while (e + 1 <= last && pm[e + 1]) e++;
        if (e - s + 1 > blen) begin blen = e - s + 1; bs = s; end
        s = e + 1;
      end else begin
        s++;
      end
    end
    if (blen < MW) begin err = 1; ctr = 0; end
    else begin err = 0; ctr = bs + (blen - 1) / 2; end
  endfunction

  task automatic set_win(input int l, input int lo, input int hi);
    for (int t = lo; t <= hi && t < DT; t++) pass_m[l][t] = 1'b1;
  endtask

  task automatic clear_eyes();
    for (int l = 0; l < NL; l++) begin pass_m[l] = '0; oor_at[l] = 99; end
  endtask

  task automatic rand_eyes(input int from_lane);
    int lo, len;
    for (int l = from_lane; l < NL; l++) begin
      pass_m[l] = '0;
      lo  = int'($urandom_range(0, 28));
      len = int'($urandom_range(2, 12));
      set_win(l, lo, lo + len - 1);
      if ($urandom_range(0, 1) == 1) begin
        lo = int'($urandom_range(0, 31));
        set_win(l, lo, lo + int'($urandom_range(0, 8)));
      end
      oor_at[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 31)) : 99;
    end
  endtask

  task automatic mon_clear();
    mon_rst = 1'b1;
    @(posedge FAB_CLK);
    @(posedge FAB_CLK);
    mon_rst = 1'b0;
    @(negedge FAB_CLK);
  endtask

  task automatic kick();
    mon_clear();
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    check("busy_after_start", 32'(BUSY), 32'd1);
    check("done_cleared", 32'(DONE), 32'd0);
  endtask

  // Runs a full training; a second START is poked at cycle 'poke' while busy.
  task automatic train(input string name, input int poke);
    int c, e, bl, cyc;
    logic [31:0] w;
    kick();
    cyc = 0;
    while (!DONE && cyc < 6000) begin
      START = (cyc == poke);
      @(negedge FAB_CLK);
      cyc++;
    end
    START = 1'b0;
    check({name, "_done_in_budget"}, 32'(DONE), 32'd1);
    check({name, "_busy_low_at_done"}, 32'(BUSY), 32'd0);
    check({name, "_direction"}, 32'(DELAY_LINE_DIRECTION), 32'(4'hF));
    for (int l = 0; l < NL; l++) begin
      ref_lane(pass_m[l], oor_at[l], c, e, bl);
      check($sformatf("%s_center%0d", name, l), 32'(CENTER_TAP[l*TW +: TW]), 32'(c));
      check($sformatf("%s_error%0d", name, l), 32'(ERROR[l]), 32'(e));
      check($sformatf("%s_moves%0d", name, l), 32'(moves_c[l]), 32'(c));
`ifdef DQS_TRAIN_WINDOW_REPORT_EN
      check($sformatf("%s_winlen%0d", name, l), 32'(WINDOW_LEN[l*TW +: TW]), 32'(bl));
`endif
    end
    w = '0;
    for (int i = 0; i < load_seq.size() && i < 8; i++) w |= 32'(load_seq[i]) << (4 * i);
    check({name, "_load_count"}, 32'(load_seq.size()), 32'd8);
    check({name, "_load_order"}, w, 32'h3322_1100);
    check({name, "_lane_isolation"}, 32'(mon_bad), 32'd0);
    check({name, "_move_spacing"}, 32'(mon_consec), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 32'(BUSY), 32'd0);
    check({name, "_done"}, 32'(DONE), 32'd0);
    check({name, "_error"}, 32'(ERROR), 32'd0);
    check({name, "_center"}, CENTER_TAP, 32'd0);
    check({name, "_pulses"}, 32'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS}), 32'd0);
    check({name, "_direction"}, 32'(DELAY_LINE_DIRECTION), 32'd0);
  endtask

  task automatic set_lane_eyes();
    clear_eyes();
    set_win(0, 2, 9);
    set_win(1, 8, 17);
    set_win(2, 20, 30);
    set_win(3, 0, 5);
    set_win(3, 25, 31);
  endtask

  initial begin
    int cyc;
    START   = 1'b0;
    RESET_N = 1'b0;
    clear_eyes();
    for (int l = 0; l < NL; l++) tap_e[l] = 0;
    repeat (3) @(negedge FAB_CLK);
    check_all_zero("reset");

    // START coinciding with reset is lost.
    START = 1'b1;
    @(negedge FAB_CLK);
    START   = 1'b0;
    RESET_N = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    check("start_in_reset_busy", 32'(BUSY), 32'd0);
    check("start_in_reset_done", 32'(DONE), 32'd0);

    // Single window 10..19 on lane 0, with a stray START while busy.
    clear_eyes(); set_win(0, 10, 19); rand_eyes(1);
    train("win10_19", 60);
    check("win10_19_center_const", 32'(CENTER_TAP[TW-1:0]), 32'd14);

    // Two equal windows: the lower one wins.
    clear_eyes(); set_win(0, 3, 6); set_win(0, 20, 23); rand_eyes(1);
    train("tie", -1);
    check("tie_center_const", 32'(CENTER_TAP[TW-1:0]), 32'd4);

    // Window shorter than the minimum.
    clear_eyes(); set_win(0, 5, 7); rand_eyes(1);
    train("short", -1);
    check("short_error_const", 32'(ERROR[0]), 32'd1);

    // End stop at tap 15 truncates the scan; taps past it would widen the eye.
    clear_eyes(); set_win(0, 12, 20); oor_at[0] = 15; rand_eyes(1);
    train("oor", -1);
    check("oor_center_const", 32'(CENTER_TAP[TW-1:0]), 32'd13);

    // Random eyes on every lane.
    for (int r = 0; r < 5; r++) begin
      rand_eyes(0);
      train($sformatf("rand%0d", r), int'($urandom_range(10, 500)));
    end

    // Distinct eye per lane, then reset during lane 1 centring and retrain.
    set_lane_eyes();
    train("lanes", -1);
    kick();
    cyc = 0;
    while (!(load_seq.size() >= 4 && moves_c[1] >= 1) && cyc < 6000) begin
      @(negedge FAB_CLK);
      cyc++;
    end
    check("reach_lane1_cstep", 32'(cyc < 6000), 32'd1);
    RESET_N = 1'b0;
    @(negedge FAB_CLK);
    check_all_zero("midreset");
    RESET_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    check("midreset_idle", 32'(BUSY), 32'd0);
    train("retrain", -1);
    check("retrain_center1_const", 32'(CENTER_TAP[2*TW-1:TW]), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
